// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS core: walks one instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath selects/enables and counts retirements.
module multicycle_ctrl #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_en,
    output logic                ir_en,
    output logic                rf_we,
    output logic                mem_req,
    output logic                mem_we,
    output logic [1:0]          regdst_sel,
    output logic                alusrc_sel,
    output logic [1:0]          wd_sel,
    output logic [1:0]          npc_sel,
    output logic [2:0]          alu_op,
    output logic                ext_op,
    output logic [2:0]          state,
    output logic                instr_done,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t cur_state;
    state_t next_state;

    logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, is_jal, is_skip;

    // Instruction class decode; opcode/funct are stable from DECODE onward.
    always_comb begin
        is_r    = (opcode == 6'b000000);
        is_addu = is_r && (funct == 6'b100001);
        is_subu = is_r && (funct == 6'b100011);
        is_jr   = is_r && (funct == 6'b001000);
        is_ori  = (opcode == 6'b001101);
        is_lui  = (opcode == 6'b001111);
        is_lw   = (opcode == 6'b100011);
        is_sw   = (opcode == 6'b101011);
        is_beq  = (opcode == 6'b000100);
        is_j    = (opcode == 6'b000010);
        is_jal  = (opcode == 6'b000011);
        is_skip = !(is_addu || is_subu || is_jr || is_ori || is_lui ||
                    is_lw || is_sw || is_beq || is_j || is_jal);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state and combinational outputs; reset forces every output low.
    always_comb begin
        next_state = cur_state;
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        rf_we      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        regdst_sel = 2'b00;
        alusrc_sel = 1'b0;
        wd_sel     = 2'b00;
        npc_sel    = 2'b00;
        alu_op     = 3'b000;
        ext_op     = 1'b0;
        instr_done = 1'b0;
        if (reset) begin
            next_state = S_FETCH;
        end else begin
            case (cur_state)
                S_FETCH: begin
                    ir_en      = 1'b1;
                    next_state = S_DECODE;
                end
                S_DECODE: begin
                    if (is_j || is_jal || is_jr || is_skip) begin
                        pc_en      = 1'b1;
                        instr_done = 1'b1;
                        next_state = S_FETCH;
                        if (is_jr) begin
                            npc_sel = 2'b11;
                        end else if (is_skip) begin
                            npc_sel = 2'b00;
                        end else begin
                            npc_sel = 2'b10;
                        end
                        if (is_jal) begin
                            rf_we      = 1'b1;
                            regdst_sel = 2'b10;
                            wd_sel     = 2'b10;
                        end else begin
                            rf_we = 1'b0;
                        end
                    end else begin
                        next_state = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_addu) begin
                        alu_op     = 3'b000;
                        next_state = S_WB;
                    end else if (is_subu) begin
                        alu_op     = 3'b001;
                        next_state = S_WB;
                    end else if (is_ori) begin
                        alusrc_sel = 1'b1;
                        alu_op     = 3'b010;
                        next_state = S_WB;
                    end else if (is_lui) begin
                        alusrc_sel = 1'b1;
                        alu_op     = 3'b011;
                        next_state = S_WB;
                    end else if (is_lw || is_sw) begin
                        alusrc_sel = 1'b1;
                        ext_op     = 1'b1;
                        next_state = S_MEM;
                    end else if (is_beq) begin
                        alu_op     = 3'b001;
                        ext_op     = 1'b1;
                        pc_en      = 1'b1;
                        npc_sel    = zero ? 2'b01 : 2'b00;
                        instr_done = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_FETCH;
                    end
                end
                S_MEM: begin
                    // Address selects stay as in EXEC while the memory stalls.
                    mem_req    = 1'b1;
                    alusrc_sel = 1'b1;
                    ext_op     = 1'b1;
                    if (!mem_ready) begin
                        next_state = S_MEM;
                    end else if (is_lw) begin
                        next_state = S_WB;
                    end else begin
                        mem_we     = 1'b1;
                        pc_en      = 1'b1;
                        instr_done = 1'b1;
                        next_state = S_FETCH;
                    end
                end
                S_WB: begin
                    rf_we      = 1'b1;
                    pc_en      = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                    if (is_r) begin
                        regdst_sel = 2'b01;
                    end else if (is_lw) begin
                        wd_sel = 2'b01;
                    end else begin
                        regdst_sel = 2'b00;
                    end
                end
                default: begin
                    next_state = S_FETCH;
                end
            endcase
        end
    end

    assign state = cur_state;

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired <= {RETIRE_W{1'b0}};
        end else if (instr_done) begin
            retired <= retired + RETIRE_W'(1);
        end else begin
            retired <= retired;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state/output tables with
// hand-computed expectations, plus reset and counter-wrap scenarios.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       pc_en, ir_en, rf_we, mem_req, mem_we, alusrc_sel, ext_op, instr_done;
    logic [1:0] regdst_sel, wd_sel, npc_sel;
    logic [2:0] alu_op, state;
    logic [3:0] retired;

    int vectors = 0;
    int miscompares = 0;

    multicycle_ctrl #(.RETIRE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .ir_en(ir_en), .rf_we(rf_we),
        .mem_req(mem_req), .mem_we(mem_we), .regdst_sel(regdst_sel),
        .alusrc_sel(alusrc_sel), .wd_sel(wd_sel), .npc_sel(npc_sel),
        .alu_op(alu_op), .ext_op(ext_op), .state(state),
        .instr_done(instr_done), .retired(retired)
    );

    always #5 clk = ~clk;

    // Field order: pc ir rf mreq mwe regdst(2) alusrc wd(2) npc(2) alu(3) ext done
    wire [16:0] outs = {pc_en, ir_en, rf_we, mem_req, mem_we, regdst_sel, alusrc_sel,
                        wd_sel, npc_sel, alu_op, ext_op, instr_done};

    localparam logic [16:0] O_IDLE   = 17'b0_0_0_0_0_00_0_00_00_000_0_0;
    localparam logic [16:0] O_FETCH  = 17'b0_1_0_0_0_00_0_00_00_000_0_0;
    localparam logic [16:0] O_R_WB   = 17'b1_0_1_0_0_01_0_00_00_000_0_1;
    localparam logic [16:0] O_SUBU_E = 17'b0_0_0_0_0_00_0_00_00_001_0_0;
    localparam logic [16:0] O_ORI_E  = 17'b0_0_0_0_0_00_1_00_00_010_0_0;
    localparam logic [16:0] O_LUI_E  = 17'b0_0_0_0_0_00_1_00_00_011_0_0;
    localparam logic [16:0] O_I_WB   = 17'b1_0_1_0_0_00_0_00_00_000_0_1;
    localparam logic [16:0] O_LDST_E = 17'b0_0_0_0_0_00_1_00_00_000_1_0;
    localparam logic [16:0] O_MEMW   = 17'b0_0_0_1_0_00_1_00_00_000_1_0;
    localparam logic [16:0] O_SW_END = 17'b1_0_0_1_1_00_1_00_00_000_1_1;
    localparam logic [16:0] O_LW_WB  = 17'b1_0_1_0_0_00_0_01_00_000_0_1;
    localparam logic [16:0] O_BEQ_T  = 17'b1_0_0_0_0_00_0_00_01_001_1_1;
    localparam logic [16:0] O_BEQ_N  = 17'b1_0_0_0_0_00_0_00_00_001_1_1;
    localparam logic [16:0] O_J      = 17'b1_0_0_0_0_00_0_00_10_000_0_1;
    localparam logic [16:0] O_JAL    = 17'b1_0_1_0_0_10_0_10_10_000_0_1;
    localparam logic [16:0] O_JR     = 17'b1_0_0_0_0_00_0_00_11_000_0_1;
    localparam logic [16:0] O_SKIP   = 17'b1_0_0_0_0_00_0_00_00_000_0_1;

    task automatic test_reset();
        opcode = 6'h00; funct = 6'h00; zero = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (state !== 3'd0 || outs !== O_IDLE || retired !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_hold c%0d: state=%0d outs=%b retired=%0d, expected 0 %b 0",
                         i, state, outs, retired, O_IDLE);
            end
        end
        reset = 1'b0; mem_ready = 1'b0; zero = 1'b0; #1;
        vectors++;
        if (state !== 3'd0 || outs !== O_FETCH) begin
            miscompares++;
            $display("FAIL reset_release: state=%0d outs=%b, expected 0 %b", state, outs, O_FETCH);
        end
        @(posedge clk); #1;
        vectors++;
        if (state !== 3'd1 || outs !== O_SKIP) begin
            miscompares++;
            $display("FAIL first_decode: state=%0d outs=%b, expected 1 %b", state, outs, O_SKIP);
        end
        @(posedge clk); #1;
        vectors++;
        if (state !== 3'd0 || retired !== 4'd1) begin
            miscompares++;
            $display("FAIL first_retire: state=%0d retired=%0d, expected 0 1", state, retired);
        end
    endtask

    task automatic test_addu();
        logic [2:0]  es [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        logic [16:0] eo [4] = '{O_FETCH, O_IDLE, O_IDLE, O_R_WB};
        opcode = 6'h00; funct = 6'h21; zero = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (state !== es[i] || outs !== eo[i]) begin
                miscompares++;
                $display("FAIL addu c%0d: state=%0d outs=%b, expected %0d %b", i, state, outs, es[i], eo[i]);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (state !== 3'd0 || retired !== 4'd2) begin
            miscompares++;
            $display("FAIL addu_retire: state=%0d retired=%0d, expected 0 2", state, retired);
        end
    endtask

    task automatic test_lw_wait();
        logic [2:0]  es [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
        logic        rs [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [16:0] eo [7] = '{O_FETCH, O_IDLE, O_LDST_E, O_MEMW, O_MEMW, O_MEMW, O_LW_WB};
        opcode = 6'h23; funct = 6'h21; zero = 1'b0;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rs[i]; #1;
            vectors++;
            if (state !== es[i] || outs !== eo[i]) begin
                miscompares++;
                $display("FAIL lw_wait c%0d: state=%0d outs=%b, expected %0d %b", i, state, outs, es[i], eo[i]);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (state !== 3'd0 || retired !== 4'd3) begin
            miscompares++;
            $display("FAIL lw_retire: state=%0d retired=%0d, expected 0 3", state, retired);
        end
    endtask

    task automatic test_beq();
        logic [2:0]  es [6] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
        logic        zs [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [16:0] eo [6] = '{O_FETCH, O_IDLE, O_BEQ_T, O_FETCH, O_IDLE, O_BEQ_N};
        opcode = 6'h04; funct = 6'h00; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            zero = zs[i]; #1;
            vectors++;
            if (state !== es[i] || outs !== eo[i]) begin
                miscompares++;
                $display("FAIL beq c%0d: state=%0d outs=%b, expected %0d %b", i, state, outs, es[i], eo[i]);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (state !== 3'd0 || retired !== 4'd5) begin
            miscompares++;
            $display("FAIL beq_retire: state=%0d retired=%0d, expected 0 5", state, retired);
        end
    endtask

    task automatic test_jal_skip();
        logic [5:0]  ops [4] = '{6'h03, 6'h03, 6'h3F, 6'h3F};
        logic [2:0]  es  [4] = '{3'd0, 3'd1, 3'd0, 3'd1};
        logic [16:0] eo  [4] = '{O_FETCH, O_JAL, O_FETCH, O_SKIP};
        funct = 6'h21; zero = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            opcode = ops[i]; #1;
            vectors++;
            if (state !== es[i] || outs !== eo[i]) begin
                miscompares++;
                $display("FAIL jal_skip c%0d: state=%0d outs=%b, expected %0d %b", i, state, outs, es[i], eo[i]);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (state !== 3'd0 || retired !== 4'd7) begin
            miscompares++;
            $display("FAIL jal_skip_retire: state=%0d retired=%0d, expected 0 7", state, retired);
        end
    endtask

    // subu, ori, lui, sw (ready at once), j, jr back to back.
    task automatic test_other_ops();
        logic [5:0]  ops [20] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0D, 6'h0D, 6'h0D, 6'h0D,
                                  6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h2B, 6'h2B, 6'h2B, 6'h2B,
                                  6'h02, 6'h02, 6'h00, 6'h00};
        logic [5:0]  fns [20] = '{6'h23, 6'h23, 6'h23, 6'h23, 6'h21, 6'h21, 6'h21, 6'h21,
                                  6'h08, 6'h08, 6'h08, 6'h08, 6'h21, 6'h21, 6'h21, 6'h21,
                                  6'h21, 6'h21, 6'h08, 6'h08};
        logic [2:0]  es  [20] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd4,
                                  3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3,
                                  3'd0, 3'd1, 3'd0, 3'd1};
        logic [16:0] eo  [20] = '{O_FETCH, O_IDLE, O_SUBU_E, O_R_WB, O_FETCH, O_IDLE, O_ORI_E, O_I_WB,
                                  O_FETCH, O_IDLE, O_LUI_E, O_I_WB, O_FETCH, O_IDLE, O_LDST_E, O_SW_END,
                                  O_FETCH, O_J, O_FETCH, O_JR};
        zero = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            opcode = ops[i]; funct = fns[i]; #1;
            vectors++;
            if (state !== es[i] || outs !== eo[i]) begin
                miscompares++;
                $display("FAIL other_ops c%0d: state=%0d outs=%b, expected %0d %b", i, state, outs, es[i], eo[i]);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (state !== 3'd0 || retired !== 4'd13) begin
            miscompares++;
            $display("FAIL other_ops_retire: state=%0d retired=%0d, expected 0 13", state, retired);
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [2:0]  es [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        logic [16:0] eo [4] = '{O_FETCH, O_IDLE, O_LDST_E, O_MEMW};
        opcode = 6'h2B; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (state !== es[i] || outs !== eo[i]) begin
                miscompares++;
                $display("FAIL sw_pre_reset c%0d: state=%0d outs=%b, expected %0d %b", i, state, outs, es[i], eo[i]);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1; reset = 1'b1; #1;
        vectors++;
        if (state !== 3'd0 || outs !== O_IDLE || retired !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_mid_mem: state=%0d outs=%b retired=%0d, expected 0 %b 0", state, outs, retired, O_IDLE);
        end
        @(posedge clk); #1;
        vectors++;
        if (mem_we !== 1'b0 || state !== 3'd0 || retired !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_mid_mem_hold: mem_we=%b state=%0d retired=%0d, expected 0 0 0", mem_we, state, retired);
        end
        reset = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_wrap();
        opcode = 6'h02; funct = 6'h00;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            if (k == 15) begin
                vectors++;
                if (retired !== 4'd15) begin
                    miscompares++;
                    $display("FAIL wrap_pre: retired=%0d, expected 15", retired);
                end
            end else if (k == 16) begin
                vectors++;
                if (retired !== 4'd0 || state !== 3'd0) begin
                    miscompares++;
                    $display("FAIL wrap: retired=%0d state=%0d, expected 0 0", retired, state);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_lw_wait();
        test_beq();
        test_jal_skip();
        test_other_ops();
        test_reset_mid_mem();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
